// File: rtl/bitwise_seq_pkg.sv
// rtl/bitwise_seq_pkg.sv - shared constants and types for the bitwise command sequencer
//
// Holds the state encodings, op-class codes, ALU function codes, the one-hot
// writeback/B-operand selects and the decoded control bundle shared by
// bitwise_seq and bitwise_seq_decode.

package bitwise_seq_pkg;

    // FSM state encodings; codes 5..7 are unreachable and recover to IDLE
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RDA  = 3'd2;
    localparam logic [2:0] ST_RDB  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

    // op[3:2] command classes
    localparam logic [1:0] CLS_LOAD = 2'b00;
    localparam logic [1:0] CLS_AND  = 2'b01;
    localparam logic [1:0] CLS_OR   = 2'b10;
    localparam logic [1:0] CLS_XOR  = 2'b11;

    // ALU function codes
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_XOR  = 2'b11;

    // one-hot writeback source
    localparam logic [2:0] TSEL_IN   = 3'b001;
    localparam logic [2:0] TSEL_ALU  = 3'b010;
    localparam logic [2:0] TSEL_TEMP = 3'b100;

    // one-hot ALU B-operand source
    localparam logic [2:0] BSEL_RF   = 3'b001;
    localparam logic [2:0] BSEL_ZERO = 3'b010;
    localparam logic [2:0] BSEL_IN   = 3'b100;

    // decoded datapath controls for one state
    typedef struct packed {
        logic       done;
        logic [1:0] rn;
        logic       w;
        logic [1:0] sr;
        logic       lt;
        logic [1:0] aluop;
        logic [2:0] tsel;
        logic [2:0] bsel;
    } ctrl_t;

    // values driven on every field a state does not use
    localparam ctrl_t CTRL_DEFAULT = '{
        done:  1'b0,
        rn:    2'b00,
        w:     1'b0,
        sr:    2'b00,
        lt:    1'b0,
        aluop: ALU_PASS,
        tsel:  TSEL_IN,
        bsel:  BSEL_RF
    };

    // map an ALU command class onto the ALU function that implements it
    function automatic logic [1:0] class_to_aluop(input logic [1:0] cls);
        logic [1:0] f;
        case (cls)
            CLS_AND: f = ALU_AND;
            CLS_OR:  f = ALU_OR;
            CLS_XOR: f = ALU_XOR;
            default: f = ALU_PASS;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bitwise_seq_decode.sv
// rtl/bitwise_seq_decode.sv - combinational state/op to datapath-control decoder
//
// Ports:
//   state - current FSM state (3 bits)
//   op_q  - latched command: [3:2] class, [1:0] register index rr
//   ctrl  - decoded control bundle (done, rn, w, sr, lt, aluop, tsel, bsel)

module bitwise_seq_decode
    import bitwise_seq_pkg::*;
(
    input  logic [2:0] state,
    input  logic [3:0] op_q,
    output ctrl_t      ctrl
);

    logic [1:0] rr;
    logic [1:0] cls;

    assign rr  = op_q[1:0];
    assign cls = op_q[3:2];

    always_comb begin
        ctrl = CTRL_DEFAULT;
        case (state)
            ST_IDLE: begin
                ctrl.done = 1'b1;
            end
            ST_LOAD: begin
                ctrl.w    = 1'b1;
                ctrl.rn   = rr;
                ctrl.tsel = TSEL_IN;
            end
            ST_RDA: begin
                // capture R[rr] into the temp register as ALU operand A
                ctrl.sr = rr;
                ctrl.lt = 1'b1;
            end
            ST_RDB: begin
                // operand B is R0 read through the register-file port
                ctrl.sr    = 2'b00;
                ctrl.aluop = class_to_aluop(cls);
                ctrl.bsel  = BSEL_RF;
            end
            ST_WB: begin
                // ALU controls held from RDB so the result is stable at the write
                ctrl.w     = 1'b1;
                ctrl.rn    = 2'b00;
                ctrl.sr    = 2'b00;
                ctrl.tsel  = TSEL_ALU;
                ctrl.aluop = class_to_aluop(cls);
                ctrl.bsel  = BSEL_RF;
            end
            default: begin
                // unreachable encodings: defaults, no write, done low
            end
        endcase
    end

endmodule

// File: rtl/bitwise_seq.sv
// rtl/bitwise_seq.sv - command sequencer for a register-file bitwise datapath
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   s      - start request, sampled only in IDLE
//   op     - command: [3:2] class (LOAD/AND/OR/XOR), [1:0] register index rr
//   done   - high only in IDLE (ready for a command)
//   Rn     - register-file write index
//   w      - register-file write enable
//   sr     - register-file read index
//   lt     - temp-register load enable
//   aluop  - ALU function (pass/AND/OR/XOR)
//   tsel   - one-hot writeback source (in / ALU / temp)
//   bsel   - one-hot ALU B source (register file / zero / in)

module bitwise_seq
    import bitwise_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [3:0] op,
    output logic       done,
    output logic [1:0] Rn,
    output logic       w,
    output logic [1:0] sr,
    output logic       lt,
    output logic [1:0] aluop,
    output logic [2:0] tsel,
    output logic [2:0] bsel
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] op_q;
    logic       accept;
    ctrl_t      ctrl;

    // a command is taken only from IDLE; s/op are ignored everywhere else
    assign accept = (state == ST_IDLE) && s;

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_nxt = (op[3:2] == CLS_LOAD) ? ST_LOAD : ST_RDA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: state_nxt = ST_IDLE;
            ST_RDA:  state_nxt = ST_RDB;
            ST_RDB:  state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            op_q  <= 4'b0000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= op;
            end
        end
    end

    bitwise_seq_decode u_decode (
        .state (state),
        .op_q  (op_q),
        .ctrl  (ctrl)
    );

    assign done  = ctrl.done;
    assign Rn    = ctrl.rn;
    assign w     = ctrl.w;
    assign sr    = ctrl.sr;
    assign lt    = ctrl.lt;
    assign aluop = ctrl.aluop;
    assign tsel  = ctrl.tsel;
    assign bsel  = ctrl.bsel;

endmodule

// File: doc/bitwise_seq.md
BITWISE_SEQ -- requirements
Module: bitwise_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 s  input  1  start request, sampled only in IDLE.
REQ-005 op  input  4  command: op[3:2] class (00 LOAD, 01 AND, 10 OR, 11 XOR), op[1:0] register index rr.
REQ-006 done  output  1  high when idle and ready for a command.
REQ-007 Rn  output  2  datapath write-register index.
REQ-008 w  output  1  datapath register-file write enable.
REQ-009 sr  output  2  datapath read-register index.
REQ-010 lt  output  1  datapath temp-register load enable.
REQ-011 aluop  output  2  ALU function: 00 pass, 01 AND, 10 OR, 11 XOR.
REQ-012 tsel  output  3  one-hot writeback source: 001 in, 010 ALU result, 100 temp.
REQ-013 bsel  output  3  one-hot ALU B-operand source: 001 register file, 010 zero, 100 in.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, RDA, RDB, WB; all outputs are Moore (decoded from state and latched op only).
REQ-015 In IDLE with s=1, op SHALL be latched into an internal register; the next state is LOAD for class 00, otherwise RDA.
REQ-016 s=0 in IDLE SHALL hold IDLE; s and op in any other state SHALL be ignored, with no effect on the latched op.
REQ-017 LOAD: w=1, Rn=rr, tsel=001; next state IDLE.
REQ-018 RDA: sr=rr, lt=1, w=0; next state RDB.
REQ-019 RDB: sr=00, bsel=001, aluop from class (01 AND, 10 OR, 11 XOR), w=0; next state WB.
REQ-020 WB: w=1, Rn=00, tsel=010, aluop and bsel held as in RDB, sr=00; next state IDLE. The result is R0 <= R[rr] op R0.
REQ-021 done SHALL be 1 only in IDLE.
REQ-022 Latency from the s-accept edge to done=1: LOAD 2 cycles; AND/OR/XOR 4 cycles.
REQ-023 w SHALL be 1 in exactly one cycle per accepted command; no write in IDLE, RDA or RDB.
REQ-024 Default output values in any state where a field is unused: Rn=00, sr=00, lt=0, w=0, aluop=00, tsel=001, bsel=001; no X values on any output.
REQ-025 s held high continuously SHALL start a new command on each IDLE cycle, so done pulses for one cycle between commands.
REQ-026 rr=00 with an ALU class is legal: AND/OR yield R0, XOR yields 0.
REQ-027 Unreachable state encodings SHALL return to IDLE on the next edge with w=0.

Reset
REQ-028 While reset=1 at a clk edge, state SHALL become IDLE and the latched op SHALL become 0000.
REQ-029 After reset, outputs SHALL take their IDLE defaults with done=1.
REQ-030 Reset asserted mid-command (RDA, RDB or WB) SHALL abort the command; no w=1 cycle occurs after the reset edge.
REQ-031 reset SHALL take priority over s in the same cycle.

Structure
REQ-032 A shared package SHALL hold the state enumeration, the op-class codes, the aluop codes and the one-hot tsel/bsel constants.
REQ-033 A single sub-module, bitwise_seq_decode, SHALL be the combinational state/op-to-control decoder; the state register and op latch stay in bitwise_seq.
REQ-034 The top-level test wrapper SHALL instantiate bitwise_seq driving the existing datapath directly.

Verification
REQ-035 Reset, then s=1, op=0010, in=8'hA5 -> w=1, Rn=10, tsel=001 in cycle 1; done=1 in cycle 2; R2=A5.
REQ-036 With R0=F0 and R1=3C: s=1, op=0101 -> cycle sequence RDA(sr=01, lt=1), RDB(aluop=01), WB(w=1, Rn=00, tsel=010); R0=30 and done=1 at cycle 4.
REQ-037 With R0=F0 and R3=FF: ops 1011 then 1111 back-to-back (s held high) -> R0=FF after OR, then R0=00 after XOR; done high for exactly one cycle between the commands.
REQ-038 Start XOR, change op and pulse s during RDB -> result uses the original op; the second request is not executed.
REQ-039 Start AND, assert reset in WB-1 (RDB) -> no w=1 cycle; next cycle IDLE with done=1; R0 unchanged.
REQ-040 A bench assertion over all tests SHALL check: w=1 in at most one cycle per accepted s, and done=1 if and only if the state is IDLE.
